// File: rtl/layer_engine_pkg.sv
// layer_engine_pkg: shared FSM states, default widths and saturating fixed-point helpers
package layer_engine_pkg;

   localparam int Q_INT_DEF  = 8;
   localparam int Q_FRAC_DEF = 8;
   localparam int Q_W_DEF    = Q_INT_DEF + Q_FRAC_DEF;

   typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, DRAIN, DONE} layer_state_e;

   // clamp a wide signed value into the signed range of a w-bit word
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction

   // signed add, saturated to a Q(q_int.q_frac) word
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b,
                                                 input int q_int, input int q_frac);
      return sat_w(a + b, q_int + q_frac);
   endfunction

   // full-precision signed product, floor-shifted back to Q format, then saturated
   function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a, input logic signed [63:0] b,
                                                 input int q_int, input int q_frac);
      return sat_w((a * b) >>> q_frac, q_int + q_frac);
   endfunction

endpackage

// File: rtl/layer_engine_mac_lane.sv
// mac_lane_sat: one saturating multiply-accumulate lane with a registered accumulator
module mac_lane_sat import layer_engine_pkg::*; #(
   parameter  int Q_INT  = Q_INT_DEF,
   parameter  int Q_FRAC = Q_FRAC_DEF,
   localparam int Q_W    = Q_INT + Q_FRAC
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  load,
   input  logic signed [Q_W-1:0] x,
   input  logic signed [Q_W-1:0] w,
   output logic signed [Q_W-1:0] acc
);

   logic signed [Q_W-1:0] acc_q, acc_d, prod;

   // first element of a pass replaces the accumulator, later elements add with saturation
   always_comb begin
      prod  = Q_W'(sat_mul(64'(x), 64'(w), Q_INT, Q_FRAC));
      acc_d = !en ? acc_q : load ? prod : Q_W'(sat_add(64'(acc_q), 64'(prod), Q_INT, Q_FRAC));
   end

   // accumulator register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) acc_q <= '0;
      else acc_q <= acc_d;

   assign acc = acc_q;

endmodule

// File: rtl/layer_engine.sv
// layer_engine: runs one fully connected layer in passes of NU_COUNT saturating MAC lanes
module layer_engine import layer_engine_pkg::*; #(
   parameter  int NU_COUNT = 4,
   parameter  int Q_INT    = Q_INT_DEF,
   parameter  int Q_FRAC   = Q_FRAC_DEF,
   parameter  int XY_DEPTH = 10,
   parameter  int W_DEPTH  = 10,
   localparam int Q_W      = Q_INT + Q_FRAC
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [XY_DEPTH-1:0]       input_base,
   input  logic [XY_DEPTH-1:0]       input_len,
   input  logic [XY_DEPTH-1:0]       output_base,
   input  logic [XY_DEPTH-1:0]       neuron_count,
   output logic                      busy,
   output logic                      done,
   output logic [XY_DEPTH-1:0]       xy_read_addr,
   input  logic signed [Q_W-1:0]     xy_read_data,
   output logic [W_DEPTH-1:0]        w_read_addr,
   input  logic [NU_COUNT*Q_W-1:0]   w_read_data,
   output logic signed [Q_W-1:0]     act_x,
   input  logic signed [Q_W-1:0]     act_fx,
   output logic                      xy_write_enable,
   output logic [XY_DEPTH-1:0]       xy_write_addr,
   output logic signed [Q_W-1:0]     xy_write_data
);

   layer_state_e          state_q, state_d;
   logic [XY_DEPTH-1:0]   cnt_q, cnt_d;
   logic [XY_DEPTH-1:0]   in_base_q, in_base_d;
   logic [XY_DEPTH-1:0]   len_q, len_d;
   logic [XY_DEPTH-1:0]   obase_q, obase_d;
   logic [XY_DEPTH-1:0]   rem_q, rem_d;
   logic [W_DEPTH-1:0]    wbase_q, wbase_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_first_q, rd_first_d;
   logic [XY_DEPTH-1:0]   lanes;
   logic                  launch, drain_end;
   logic signed [Q_W-1:0] acc [NU_COUNT];

   assign lanes     = rem_q >= XY_DEPTH'(NU_COUNT) ? XY_DEPTH'(NU_COUNT) : rem_q;
   assign launch    = state_q == IDLE && start;
   assign drain_end = state_q == DRAIN && cnt_q == lanes;

   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;

   // next state: empty layers skip straight to DONE, each drain either starts the next pass or finishes
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (input_len == '0 || neuron_count == '0) ? DONE : ACCUM;
         ACCUM:   if (cnt_q == len_q - XY_DEPTH'(1)) state_d = FLUSH;
         FLUSH:   state_d = DRAIN;
         DRAIN:   if (cnt_q == lanes) state_d = (rem_q == lanes) ? DONE : ACCUM;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // job registers, per-pass bases and the one-cycle read pipeline tags feeding the lanes
   always_comb begin
      cnt_d      = (state_d != state_q || state_q == IDLE || state_q == DONE) ? '0 : cnt_q + XY_DEPTH'(1);
      in_base_d  = launch ? input_base : in_base_q;
      len_d      = launch ? input_len : len_q;
      rem_d      = launch ? neuron_count : drain_end ? rem_q - lanes : rem_q;
      obase_d    = launch ? output_base : drain_end ? obase_q + XY_DEPTH'(NU_COUNT) : obase_q;
      wbase_d    = launch ? '0 : drain_end ? wbase_q + W_DEPTH'(len_q) : wbase_q;
      rd_valid_d = state_q == ACCUM;
      rd_first_d = state_q == ACCUM && cnt_q == '0;
   end

   // datapath registers
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt_q      <= '0;
         in_base_q  <= '0;
         len_q      <= '0;
         rem_q      <= '0;
         obase_q    <= '0;
         wbase_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_first_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         in_base_q  <= in_base_d;
         len_q      <= len_d;
         rem_q      <= rem_d;
         obase_q    <= obase_d;
         wbase_q    <= wbase_d;
         rd_valid_q <= rd_valid_d;
         rd_first_q <= rd_first_d;
      end

   genvar i;
   for (i = 0; i < NU_COUNT; i++) begin : g_lane
      mac_lane_sat #(.Q_INT(Q_INT), .Q_FRAC(Q_FRAC)) u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (rd_valid_q),
         .load    (rd_first_q),
         .x       (xy_read_data),
         .w       (w_read_data[i*Q_W +: Q_W]),
         .acc     (acc[i])
      );
   end

   // outputs: reads during ACCUM, drain mux into the LUT, and write-back lagging the LUT by one cycle
   always_comb begin
      busy            = state_q != IDLE;
      done            = state_q == DONE;
      xy_read_addr    = state_q == ACCUM ? in_base_q + cnt_q : '0;
      w_read_addr     = state_q == ACCUM ? wbase_q + W_DEPTH'(cnt_q) : '0;
      xy_write_enable = state_q == DRAIN && cnt_q != '0;
      xy_write_addr   = xy_write_enable ? obase_q + cnt_q - XY_DEPTH'(1) : '0;
      xy_write_data   = xy_write_enable ? act_fx : '0;
      act_x           = '0;
      for (int n = 0; n < NU_COUNT; n++)
         if (state_q == DRAIN && cnt_q < lanes && cnt_q == XY_DEPTH'(n)) act_x = acc[n];
   end

endmodule

// File: tb/tb_layer_engine.sv
// tb_layer_engine: randomized layer runs checked against a behavioural fixed-point model
module tb_layer_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  input_base = '0, input_len = '0, output_base = '0, neuron_count = '0;
   logic        busy, done, xy_write_enable;
   logic [9:0]  xy_read_addr, w_read_addr, xy_write_addr;
   logic [15:0] xy_read_data = '0, act_fx = '0, act_x, xy_write_data;
   logic [63:0] w_read_data = '0;

   logic [15:0] xy_mem [1024];
   logic [15:0] w_mem [4][1024];
   bit          act_mode = 1'b0;

   int cyc = 0, checks = 0, errors = 0;
   int launch_cyc = 0, exp_done = 0, exp_n = 0;
   int launch_id = 0, seen_id = 0, fin_id = 0, abort_id = -1, wr_idx = 0;
   logic [9:0]  exp_addr [64];
   logic [15:0] exp_data [64];
   logic [15:0] got_data [64];

   layer_engine dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .input_base(input_base), .input_len(input_len), .output_base(output_base), .neuron_count(neuron_count),
      .busy(busy), .done(done),
      .xy_read_addr(xy_read_addr), .xy_read_data(xy_read_data),
      .w_read_addr(w_read_addr), .w_read_data(w_read_data),
      .act_x(act_x), .act_fx(act_fx),
      .xy_write_enable(xy_write_enable), .xy_write_addr(xy_write_addr), .xy_write_data(xy_write_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] act_f(input logic [15:0] v);
      return act_mode ? v ^ 16'h0F0F : v;
   endfunction

   // memories and activation LUT, all one-cycle latency
   always @(posedge clk) begin
      xy_read_data <= xy_mem[xy_read_addr];
      w_read_data  <= {w_mem[3][w_read_addr], w_mem[2][w_read_addr], w_mem[1][w_read_addr], w_mem[0][w_read_addr]};
      act_fx       <= act_f(act_x);
   end

   function automatic void chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
      end
   endfunction

   function automatic logic [15:0] fsat(input longint v);
      return v > 32767 ? 16'h7FFF : (v < -32768 ? 16'h8000 : 16'(v));
   endfunction

   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      return fsat((longint'($signed(a)) * longint'($signed(b))) >>> 8);
   endfunction

   function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
      return fsat(longint'($signed(a)) + longint'($signed(b)));
   endfunction

   // expected writes and completion cycle straight from the layer definition
   task automatic build(input int ib, input int il, input int ob, input int nc);
      int lat;
      logic [15:0] a, m;
      lat = 1;
      exp_n = 0;
      a = '0;
      if (il != 0 && nc != 0)
         for (int p = 0; p * 4 < nc; p++) lat += il + ((nc - p * 4) < 4 ? nc - p * 4 : 4) + 2;
      for (int n = 0; il != 0 && n < nc; n++) begin
         for (int k = 0; k < il; k++) begin
            m = fmul(xy_mem[(ib + k) % 1024], w_mem[n % 4][((n / 4) * il + k) % 1024]);
            a = k == 0 ? m : fadd(a, m);
         end
         exp_addr[n] = 10'((ob + n) % 1024);
         exp_data[n] = act_f(a);
         exp_n++;
      end
      exp_done = cyc + lat;
   endtask

   task automatic launch(input int ib, input int il, input int ob, input int nc);
      @(negedge clk);
      build(ib, il, ob, nc);
      launch_cyc   = cyc;
      input_base   = 10'(ib);
      input_len    = 10'(il);
      output_base  = 10'(ob);
      neuron_count = 10'(nc);
      start        = 1'b1;
      launch_id++;
      @(posedge clk);
      #1 start = 1'b0;
      chk("rd_addr0", xy_read_addr, (il == 0 || nc == 0) ? 0 : ib % 1024);
      chk("w_addr0", w_read_addr, 0);
   endtask

   task automatic wait_done();
      for (int t = 0; t < 3000 && fin_id != launch_id; t++) @(negedge clk);
      chk("timeout", fin_id == launch_id, 1);
   endtask

   task automatic fill(input bit wide);
      for (int a = 0; a < 1024; a++) begin
         xy_mem[a] = wide ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
         for (int l = 0; l < 4; l++) w_mem[l][a] = wide ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      end
   endtask

   // per-cycle compare against the model while a run is live, idle expectations otherwise
   always @(negedge clk) begin
      bit live;
      if (launch_id != seen_id) begin
         seen_id = launch_id;
         wr_idx  = 0;
      end
      live = launch_id != fin_id && launch_id != abort_id && cyc > launch_cyc;
      if (live) begin
         chk("busy", busy, 1);
         chk("done", done, cyc == exp_done);
         if (xy_write_enable) begin
            if (wr_idx >= exp_n) chk("extra_write", 1, 0);
            else begin
               chk("wr_addr", xy_write_addr, exp_addr[wr_idx]);
               chk("wr_data", xy_write_data, exp_data[wr_idx]);
               got_data[wr_idx] = xy_write_data;
               wr_idx++;
            end
         end
         if (cyc == exp_done) begin
            chk("wr_count", wr_idx, exp_n);
            fin_id = launch_id;
         end
      end else begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_we", xy_write_enable, 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 1024; a++) begin
         xy_mem[a] = '0;
         for (int l = 0; l < 4; l++) w_mem[l][a] = '0;
      end
      #1 reset_n = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", xy_write_enable, 0);
      chk("rst_rd_addr", xy_read_addr, 0);
      chk("rst_act_x", act_x, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // 1.0*0.5 + 2.0*0.25 = 1.0 through the identity LUT, done in cycle 6
      xy_mem[100] = 16'h0100;
      xy_mem[101] = 16'h0200;
      w_mem[0][0] = 16'h0080;
      w_mem[0][1] = 16'h0040;
      launch(100, 2, 300, 1);
      chk("t1_model_data", exp_data[0], 16'h0100);
      chk("t1_model_lat", exp_done - launch_cyc, 6);
      wait_done();
      chk("t1_dut_data", got_data[0], 16'h0100);

      // saturation in both directions
      xy_mem[50] = 16'h7F00;
      xy_mem[51] = 16'h7F00;
      w_mem[0][0] = 16'h7F00;
      w_mem[0][1] = 16'h7F00;
      w_mem[1][0] = 16'h8100;
      w_mem[1][1] = 16'h8100;
      launch(50, 2, 400, 2);
      wait_done();
      chk("sat_pos", got_data[0], 16'h7FFF);
      chk("sat_neg", got_data[1], 16'h8000);

      // two passes, lanes 4 then 2
      fill(1'b0);
      launch(20, 3, 500, 6);
      chk("t2_model_lat", exp_done - launch_cyc, 17);
      wait_done();

      // empty layers
      launch(7, 0, 600, 5);
      chk("zero_l_lat", exp_done - launch_cyc, 1);
      wait_done();
      launch(7, 4, 600, 0);
      wait_done();

      // reset in the middle of a drain, then a clean run
      act_mode = 1'b1;
      launch(30, 3, 700, 6);
      for (int t = 0; t < 100 && !xy_write_enable; t++) @(negedge clk);
      chk("drain_reached", xy_write_enable, 1);
      @(posedge clk);
      #2;
      abort_id = launch_id;
      reset_n  = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_we", xy_write_enable, 0);
      chk("abort_waddr", xy_write_addr, 0);
      chk("abort_wdata", xy_write_data, 0);
      chk("abort_act_x", act_x, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      launch(30, 3, 700, 6);
      wait_done();

      // start and input changes while busy are ignored
      launch(10, 4, 200, 5);
      repeat (3) @(negedge clk);
      start        = 1'b1;
      input_base   = 10'd0;
      input_len    = 10'd0;
      output_base  = 10'd7;
      neuron_count = 10'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // random layers, including address wrap and wide-range data
      for (int r = 0; r < 20; r++) begin
         act_mode = r[0];
         fill(r % 4 == 3);
         launch($urandom_range(0, 1023), $urandom_range(1, 8), (r % 5 == 0) ? 1020 : $urandom_range(0, 1023),
                $urandom_range(1, 13));
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
